bist_checker: RTL

- Response-side companion to the BIST pattern generator: consumes the generator's read strobe, address and expected data, aligns them to SRAM read latency, and compares against SRAM dout.
- Produces sticky fail, saturating mismatch count, first-failure capture and a per-bit failure map for the BIST controller / scan readout.
- Sits between the patgen outputs, the SRAM macro's dout and the BIST top, and drives the interface's fail and done.

---
 rtl/bist_checker.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bist_checker.sv
// bist_checker: aligns the pattern generator's reads with SRAM dout and compares them.
// It keeps a sticky fail flag, a saturating fail count, the first failure and a per-bit failure map.
// Latency: a read's result is visible READ_LATENCY+1 cycles after the read. done rises READ_LATENCY+1 cycles after patgen_done.
// Backpressure: none; every qualified read is compared exactly once.
// Ports: start/en/re/addr/check/patgen_done come from the pattern generator, and dout from the SRAM.
// busy/done/fail*/fail_bits go to the BIST controller and scan readout.
module bist_checker #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1,   // 1..4
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  en,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] check,
  input  logic                  patgen_done,
  input  logic [DATA_WIDTH-1:0] dout,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_WIDTH-1:0]  fail_count,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_actual,
  output logic [DATA_WIDTH-1:0] fail_bits
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int                   LAST    = READ_LATENCY - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [2:0]           DRAIN_LOAD = 3'(READ_LATENCY);

  state_t                  state;
  logic [2:0]              drain_cnt;

  // Alignment pipeline. Stage LAST lines up with the dout of the same read.
  logic [READ_LATENCY-1:0] pipe_vld;
  logic [ADDR_WIDTH-1:0]   pipe_addr [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   pipe_chk  [READ_LATENCY];

  logic                    launch;
  logic                    cmp_vld;
  logic [DATA_WIDTH-1:0]   diff;
  logic                    mismatch;

  // A read that coincides with start belongs to the aborted run, so it is dropped.
  assign launch   = en && re && (state == RUN) && !start;
  // start wins over a compare that lands on the same edge, because the results are being cleared.
  assign cmp_vld  = pipe_vld[LAST] && ((state == RUN) || (state == DRAIN)) && !start;
  assign diff     = dout ^ pipe_chk[LAST];
  assign mismatch = |diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_addr[i] <= '0;
        pipe_chk[i]  <= '0;
      end
    end else begin
      pipe_vld[0]  <= launch;
      pipe_addr[0] <= addr;
      pipe_chk[0]  <= check;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld[i]  <= pipe_vld[i-1] && !start;
        pipe_addr[i] <= pipe_addr[i-1];
        pipe_chk[i]  <= pipe_chk[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      drain_cnt     <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      fail          <= 1'b0;
      fail_count    <= '0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
      fail_bits     <= '0;
    end else if (start) begin
      // start is a restart from any state.
      state         <= RUN;
      drain_cnt     <= '0;
      busy          <= 1'b1;
      done          <= 1'b0;
      fail          <= 1'b0;
      fail_count    <= '0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
      fail_bits     <= '0;
    end else begin
      case (state)
        IDLE: ;
        RUN: begin
          if (patgen_done) begin
            state     <= DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        DRAIN: begin
          // The count reaches 0 on the edge where the final in-flight read is compared.
          if (drain_cnt <= 3'd1) begin
            state     <= DONE;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        DONE: ;
        default: state <= IDLE;
      endcase

      if (cmp_vld) begin
        fail_bits <= fail_bits | diff;
        if (mismatch) begin
          fail <= 1'b1;
          if (fail_count != '1)
            fail_count <= fail_count + CNT_ONE;
          // Capture only the first failure of the run.
          if (!fail) begin
            fail_addr     <= pipe_addr[LAST];
            fail_expected <= pipe_chk[LAST];
            fail_actual   <= dout;
          end
        end
      end
    end
  end

endmodule
